// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if: byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_deser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   modport master (output rx_data, rx_valid, input rx_ready);
   modport slave (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 UART receiver with a one-entry holding register and valid/ready output.
module uart_rx_deser #(
   parameter int CLKS_PER_BIT = 108
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            uart_rx,
   uart_rx_deser_if.master rx,
   output logic            frame_err,
   output logic            overrun,
   output logic            busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
   state_t      state_q;
   logic [15:0] cnt_q;
   logic [2:0]  idx_q;
   logic [7:0]  shift_q, data_q;
   logic        valid_q, ferr_q, ovr_q, busy_q, s1_q, s2_q;
   logic        done, hs;
   assign done = (state_q == STOP) && (cnt_q == FULL_M1) && s2_q;
   assign hs = valid_q && rx.rx_ready;
   assign rx.rx_data = data_q;
   assign rx.rx_valid = valid_q;
   assign frame_err = ferr_q;
   assign overrun = ovr_q;
   assign busy = busy_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
      end else begin
         s1_q   <= uart_rx;
         s2_q   <= s1_q;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
         case (state_q)
            IDLE: if (!s2_q) begin
               state_q <= START;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
            START: if (cnt_q == HALF_M1) begin
               state_q <= s2_q ? IDLE : DATA;
               busy_q  <= !s2_q;
               cnt_q   <= '0;
               idx_q   <= '0;
            end else cnt_q <= cnt_q + 16'd1;
            DATA: if (cnt_q == FULL_M1) begin
               shift_q[idx_q] <= s2_q;
               cnt_q          <= '0;
               idx_q          <= idx_q + 3'd1;
               if (idx_q == 3'd7) state_q <= STOP;
            end else cnt_q <= cnt_q + 16'd1;
            STOP: if (cnt_q == FULL_M1) begin
               state_q <= s2_q ? IDLE : BREAK;
               busy_q  <= !s2_q;
               ferr_q  <= !s2_q;
               cnt_q   <= '0;
            end else cnt_q <= cnt_q + 16'd1;
            BREAK: if (s2_q) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
         // a completing byte may replace the held one only if it is being consumed this cycle
         if (done && valid_q && !rx.rx_ready) ovr_q <= 1'b1;
         else if (done) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
         end else if (hs) valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: byte-level scoreboard model of two receivers (108 and 16 clk/bit) checked every cycle.
module tb_uart_rx_deser;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst [2];
   logic line [2];
   logic rdy [2];
   logic dv [2], df [2], dovr [2], db [2];
   logic [7:0] dd [2];
   uart_rx_deser_if if0 ();
   uart_rx_deser_if if1 ();
   assign if0.rx_ready = rdy[0];
   assign if1.rx_ready = rdy[1];
   assign dv[0] = if0.rx_valid;
   assign dd[0] = if0.rx_data;
   assign dv[1] = if1.rx_valid;
   assign dd[1] = if1.rx_data;
   uart_rx_deser #(.CLKS_PER_BIT(108)) u0 (
      .clk(clk), .rst(rst[0]), .uart_rx(line[0]), .rx(if0),
      .frame_err(df[0]), .overrun(dovr[0]), .busy(db[0])
   );
   uart_rx_deser #(.CLKS_PER_BIT(16)) u1 (
      .clk(clk), .rst(rst[1]), .uart_rx(line[1]), .rx(if1),
      .frame_err(df[1]), .overrun(dovr[1]), .busy(db[1])
   );
   typedef struct {
      int         ch;
      int         at;
      logic [7:0] b;
      logic       ok;
   } ev_t;
   ev_t evq[$];
   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int last_k = 0;
   int ferr_n [2] = '{0, 0};
   int ovr_n [2] = '{0, 0};
   int rise_at [2] = '{0, 0};
   logic mv [2], mf [2], mo [2];
   logic [7:0] md [2];
   logic rst_p [2] = '{1'b1, 1'b1};
   logic rdy_p [2] = '{1'b1, 1'b1};
   logic dv_p [2] = '{1'b0, 1'b0};
   logic [7:0] hs0[$], hs1[$], sent[$];
   bit rnd_done = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s ch%0d: got %0h expected %0h at cycle %0d", name, c, act, exp, cyc);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // frame completion lands 3 + half + 9 bit periods after the start edge is driven
   task automatic send(input int c, input logic [7:0] b, input logic stop, input int stop_len, input int abort_bit);
      int cpb = (c == 0) ? 108 : 16;
      last_k = cyc;
      line[c] = 1'b0;
      if (abort_bit < 0) evq.push_back('{ch: c, at: cyc + 3 + cpb / 2 + 9 * cpb, b: b, ok: stop});
      repeat (cpb) tick;
      for (int i = 0; i < 8; i++) begin
         if (i == abort_bit) begin
            rst[c] = 1'b1;
            line[c] = 1'b1;
            repeat (3) tick;
            rst[c] = 1'b0;
            return;
         end
         line[c] = b[i];
         repeat (cpb) tick;
      end
      line[c] = stop;
      repeat (stop_len) tick;
      line[c] = 1'b1;
   endtask
   always @(negedge clk) begin
      ev_t ev;
      for (int c = 0; c < 2; c++) begin
         if (rst_p[c]) begin
            mv[c] = 1'b0;
            md[c] = 8'h00;
            mf[c] = 1'b0;
            mo[c] = 1'b0;
         end else begin
            mf[c] = 1'b0;
            mo[c] = 1'b0;
            if (evq.size() > 0 && evq[0].ch == c && evq[0].at == cyc) begin
               ev = evq.pop_front();
               if (!ev.ok) mf[c] = 1'b1;
               else if (!mv[c] || rdy_p[c]) begin
                  mv[c] = 1'b1;
                  md[c] = ev.b;
               end else mo[c] = 1'b1;
            end else if (mv[c] && rdy_p[c]) mv[c] = 1'b0;
         end
         chk("rx_valid", c, 32'(dv[c]), 32'(mv[c]));
         chk("rx_data", c, 32'(dd[c]), 32'(md[c]));
         chk("frame_err", c, 32'(df[c]), 32'(mf[c]));
         chk("overrun", c, 32'(dovr[c]), 32'(mo[c]));
         if (df[c]) ferr_n[c]++;
         if (dovr[c]) ovr_n[c]++;
         if (dv[c] && !dv_p[c]) rise_at[c] = cyc;
         if (!rst[c] && dv[c] && rdy[c]) begin
            if (c == 0) hs0.push_back(dd[c]);
            else hs1.push_back(dd[c]);
         end
         dv_p[c] = dv[c];
         rdy_p[c] = rdy[c];
         rst_p[c] = rst[c];
      end
   end
   initial begin
      int j;
      logic [7:0] b;
      for (int c = 0; c < 2; c++) begin
         rst[c] = 1'b1;
         line[c] = 1'b1;
         rdy[c] = 1'b1;
      end
      repeat (4) tick;
      @(negedge clk);
      chk("reset_valid", 0, 32'(dv[0]), 0);
      chk("reset_data", 0, 32'(dd[0]), 0);
      chk("reset_busy", 0, 32'(db[0]), 0);
      chk("reset_ferr", 0, 32'(df[0]), 0);
      chk("reset_ovr", 0, 32'(dovr[0]), 0);
      tick;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      repeat (3) tick;
      send(0, 8'h01, 1'b1, 108, -1);
      chk("latency", 0, rise_at[0] - last_k, 1029);
      send(0, 8'h23, 1'b1, 108, -1);
      repeat (10) tick;
      chk("two_bytes_count", 0, hs0.size(), 2);
      chk("byte_01", 0, 32'(hs0[0]), 32'h01);
      chk("byte_23", 0, 32'(hs0[1]), 32'h23);
      chk("no_ferr", 0, ferr_n[0], 0);
      chk("no_ovr", 0, ovr_n[0], 0);
      last_k = cyc;
      line[0] = 1'b0;
      repeat (20) tick;
      line[0] = 1'b1;
      @(negedge clk);
      chk("glitch_busy", 0, 32'(db[0]), 1);
      repeat (60) tick;
      @(negedge clk);
      chk("glitch_idle", 0, 32'(db[0]), 0);
      chk("glitch_no_byte", 0, hs0.size(), 2);
      chk("glitch_no_ferr", 0, ferr_n[0], 0);
      send(0, 8'hA5, 1'b0, 300, -1);
      @(negedge clk);
      chk("break_busy", 0, 32'(db[0]), 1);
      chk("break_ferr_once", 0, ferr_n[0], 1);
      chk("break_no_byte", 0, hs0.size(), 2);
      repeat (5) tick;
      @(negedge clk);
      chk("break_exit", 0, 32'(db[0]), 0);
      send(0, 8'h3C, 1'b1, 108, -1);
      repeat (5) tick;
      chk("after_break_count", 0, hs0.size(), 3);
      chk("byte_3c", 0, 32'(hs0[2]), 32'h3C);
      rdy[0] = 1'b0;
      send(0, 8'h11, 1'b1, 108, -1);
      send(0, 8'h22, 1'b1, 108, -1);
      repeat (10) tick;
      chk("overrun_once", 0, ovr_n[0], 1);
      chk("held_valid", 0, 32'(dv[0]), 1);
      chk("held_data", 0, 32'(dd[0]), 32'h11);
      rdy[0] = 1'b1;
      repeat (5) tick;
      chk("drain_count", 0, hs0.size(), 4);
      chk("drain_11", 0, 32'(hs0[3]), 32'h11);
      chk("drain_valid_low", 0, 32'(dv[0]), 0);
      send(0, 8'hFF, 1'b1, 108, 4);
      @(negedge clk);
      chk("abort_busy", 0, 32'(db[0]), 0);
      chk("abort_valid", 0, 32'(dv[0]), 0);
      repeat (2) tick;
      send(0, 8'h5A, 1'b1, 108, -1);
      repeat (5) tick;
      chk("after_rst_count", 0, hs0.size(), 5);
      chk("byte_5a", 0, 32'(hs0[4]), 32'h5A);
      chk("abort_no_ferr", 0, ferr_n[0], 1);
      chk("abort_no_ovr", 0, ovr_n[0], 1);
      fork
         begin
            for (int i = 0; i < 256; i++) begin
               b = 8'($urandom);
               sent.push_back(b);
               send(1, b, 1'b1, 16, -1);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               rdy[1] = 1'($urandom_range(0, 1));
               tick;
            end
         end
      join
      rdy[1] = 1'b1;
      repeat (20) tick;
      chk("rand_accounted", 1, hs1.size() + ovr_n[1], 256);
      chk("rand_no_ferr", 1, ferr_n[1], 0);
      j = 0;
      for (int i = 0; i < sent.size() && j < hs1.size(); i++) if (sent[i] == hs1[j]) j++;
      chk("rand_in_order", 1, j, hs1.size());
      chk("events_drained", 0, evq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 108, number of clk cycles per UART bit period; legal range 16..65535.
REQ-002 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: uart_rx  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
REQ-005 Port: rx_data  output  8  received byte, stable while rx_valid=1.
REQ-006 Port: rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 Port: rx_ready  input  1  consumer accepts the byte in any cycle where rx_valid=1 and rx_ready=1.
REQ-008 Port: frame_err  output  1  one-cycle pulse when a frame's stop bit samples 0.
REQ-009 Port: overrun  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.
REQ-010 Port: busy  output  1  high in every FSM state except IDLE.

Function
REQ-011 uart_rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; all FSM decisions use the synchronizer output (rx_s).
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; there SHALL be one bit-period counter and one 3-bit bit index.
REQ-013 IDLE: on rx_s=0, go to START and clear the counter.
REQ-014 START: at counter = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s; if 1, glitch, return to IDLE with no output; if 0, go to DATA with counter and bit index cleared.
REQ-015 DATA: at counter = CLKS_PER_BIT - 1, sample rx_s into shift bit [index], clear the counter, increment the index; after index 7, go to STOP.
REQ-016 STOP: at counter = CLKS_PER_BIT - 1, sample rx_s; if 1, the frame completes and the FSM goes to IDLE; if 0, pulse frame_err, discard the byte, and go to BREAK.
REQ-017 BREAK: stay until rx_s=1, then go to IDLE; a low line SHALL never start a new frame from BREAK.
REQ-018 Frame completion SHALL assert rx_valid in the next cycle, provided the holding register is free. Nominal latency from the uart_rx falling edge is 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, ±1 for input phase.
REQ-019 Holding register: one entry; rx_valid stays high and rx_data stays unchanged until the handshake occurs; rx_valid then drops the following cycle unless a new byte loads in that same cycle.
REQ-020 Completion while rx_valid=1 and rx_ready=0: pulse overrun, drop the new byte, and keep the old rx_data.
REQ-021 Completion in the same cycle as a handshake: load the new byte, keep rx_valid=1, and do not pulse overrun.
REQ-022 Reception SHALL continue independently of rx_ready; back-to-back frames with a one-bit stop gap SHALL be received without loss when rx_ready=1.
REQ-023 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-024 While rst=1: FSM=IDLE, counter=0, index=0, shift register=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-025 rst asserted mid-frame SHALL abort the frame with no rx_valid, frame_err or overrun; after release the next start bit is received normally.
REQ-026 The first frame SHALL be accepted no earlier than 2 cycles after rst deasserts, the time needed to flush the synchronizer.

Verification
REQ-027 Bytes 8'h01 then 8'h23 at 108 clk/bit with rx_ready=1 -> two rx_valid handshakes with rx_data 8'h01 then 8'h23, and no frame_err or overrun.
REQ-028 A 20-cycle low glitch on an idle line -> busy pulses high, then FSM returns to IDLE; no rx_valid or frame_err.
REQ-029 Byte 8'hA5 with the stop bit driven 0 for 300 cycles -> one frame_err pulse, no rx_valid, FSM stays in BREAK until the line goes high; next byte 8'h3C is received correctly.
REQ-030 Bytes 8'h11 then 8'h22 with rx_ready=0 -> rx_data=8'h11 held, one overrun pulse at the second completion; raising rx_ready yields exactly one handshake with 8'h11.
REQ-031 rst pulsed at bit 4 of byte 8'hFF -> no outputs from that frame; the subsequent byte 8'h5A is received correctly.
REQ-032 CLKS_PER_BIT=16, 256 random back-to-back bytes, rx_ready randomly toggled -> every byte handshaken in order whenever no overrun pulse occurs.
